// File: rtl/bus_responder_pkg.sv
// bus_responder_pkg
// Shared definitions for the bus responder: FSM state encoding, default
// widths and the largest supported wait-state count.
`ifndef BUS_RESPONDER_PKG_SV
`define BUS_RESPONDER_PKG_SV

package bus_responder_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_ADDR_WIDTH  = 8;
  localparam int DEFAULT_WAIT_STATES = 2;
  localparam int WAIT_STATES_MAX     = 15;

  // state | meaning
  // IDLE  | no access in progress, watching for a strobe assertion
  // WAIT  | access accepted, counting down wait states
  // DONE  | access completed, ready held until the strobe releases
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

`endif

// File: rtl/bus_responder_strobe_edge_detect.sv
// strobe_edge_detect
// Registers the previous sample of both active-low CPU strobes and reports
// a fresh assertion (low now, high on the previous edge) for each.
// Ports:
//   clock, reset        - system clock, async active-high reset
//   notRD, notWR        - active-low strobes from the CPU
//   rdAssert, wrAssert  - strobe low now and high at the previous edge
//   bothLow             - both strobes low at this edge
//   rdLevel, wrLevel    - strobe currently asserted (low)
module strobe_edge_detect (
  input  logic clock,
  input  logic reset,
  input  logic notRD,
  input  logic notWR,
  output logic rdAssert,
  output logic wrAssert,
  output logic bothLow,
  output logic rdLevel,
  output logic wrLevel
);

  logic prevRd_q;
  logic prevWr_q;

  // Previous samples start deasserted so a strobe already low when reset
  // releases counts as an assertion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prevRd_q <= 1'b1;
      prevWr_q <= 1'b1;
    end else begin
      prevRd_q <= notRD;
      prevWr_q <= notWR;
    end
  end

  assign rdLevel  = ~notRD;
  assign wrLevel  = ~notWR;
  assign rdAssert = ~notRD & prevRd_q;
  assign wrAssert = ~notWR & prevWr_q;
  assign bothLow  = ~notRD & ~notWR;

endmodule

// File: rtl/bus_responder.sv
// bus_responder
// Memory-side responder for the CPU notRD/notWR strobe pair. On a strobe
// assertion it latches the address (and write data), waits WAIT_STATES
// cycles, then either drives store data onto the bus or commits the write
// into the internal store, and holds ready until the strobe releases.
// Ports:
//   clock, reset   - system clock, async active-high reset
//   notRD, notWR   - active-low read / write strobes
//   address        - word address, sampled at the assertion edge
//   dataIn         - write data, sampled at the assertion edge
//   dataOut        - read data (holds its value after the access)
//   dataOutEnable  - high while dataOut should drive the bus
//   ready          - access complete, held until strobe release
//   busError       - one-cycle pulse on abort or both-strobes-low
//                    (only when BUS_ERROR_EN is defined)
// Build option: BUS_ERROR_EN adds the busError port and its logic.
module bus_responder
  import bus_responder_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  notRD,
  input  logic                  notWR,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataOutEnable,
  output logic                  ready
`ifdef BUS_ERROR_EN
  ,
  output logic                  busError
`endif
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  logic rdAssert, wrAssert, bothLow, rdLevel, wrLevel;

  strobe_edge_detect u_edge (
    .clock    (clock),
    .reset    (reset),
    .notRD    (notRD),
    .notWR    (notWR),
    .rdAssert (rdAssert),
    .wrAssert (wrAssert),
    .bothLow  (bothLow),
    .rdLevel  (rdLevel),
    .wrLevel  (wrLevel)
  );

  state_e                state_q, state_d;
  logic [3:0]            count_q, count_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  isWr_q, isWr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  oe_q, oe_d;
  logic                  ready_q, ready_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  memWe;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [DATA_WIDTH-1:0] memWdata;
  logic                  activeLow;

`ifdef BUS_ERROR_EN
  logic errEvent;
  logic err_q;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    addr_d    = addr_q;
    data_d    = data_q;
    isWr_d    = isWr_q;
    dout_d    = dout_q;
    oe_d      = oe_q;
    ready_d   = ready_q;
    memWe     = 1'b0;
    memAddr   = addr_q;
    memWdata  = data_q;
    activeLow = isWr_q ? wrLevel : rdLevel;
`ifdef BUS_ERROR_EN
    errEvent  = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (bothLow) begin
`ifdef BUS_ERROR_EN
          // Only the edge where a strobe newly asserts flags the conflict,
          // so a long overlap yields a single pulse.
          errEvent = rdAssert | wrAssert;
`endif
        end else if (rdAssert || wrAssert) begin
          addr_d = address;
          isWr_d = wrAssert;
          if (wrAssert) data_d = dataIn;
          if (WAIT_STATES == 0) begin
            // Zero wait states: complete on the assertion edge itself using
            // the bus values directly, since the latches are not yet loaded.
            state_d  = DONE;
            ready_d  = 1'b1;
            memAddr  = address;
            memWdata = dataIn;
            if (wrAssert) begin
              memWe = 1'b1;
            end else begin
              dout_d = mem[address];
              oe_d   = 1'b1;
            end
          end else begin
            state_d = WAIT;
            count_d = WAIT_INIT;
          end
        end
      end

      WAIT: begin
        if (!activeLow) begin
          state_d = IDLE;
`ifdef BUS_ERROR_EN
          errEvent = 1'b1;
`endif
        end else if (count_q == 4'd1) begin
          state_d = DONE;
          ready_d = 1'b1;
          if (isWr_q) begin
            memWe = 1'b1;
          end else begin
            dout_d = mem[addr_q];
            oe_d   = 1'b1;
          end
        end else begin
          count_d = count_q - 4'd1;
        end
      end

      DONE: begin
        if (!activeLow) begin
          state_d = IDLE;
          ready_d = 1'b0;
          oe_d    = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      isWr_q  <= 1'b0;
      dout_q  <= '0;
      oe_q    <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      isWr_q  <= isWr_d;
      dout_q  <= dout_d;
      oe_q    <= oe_d;
      ready_q <= ready_d;
    end
  end

  // Store is never cleared; a commit is suppressed while reset is held so an
  // interrupted write is lost.
  always_ff @(posedge clock) begin
    if (memWe && !reset) mem[memAddr] <= memWdata;
  end

`ifdef BUS_ERROR_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= errEvent;
  end
  assign busError = err_q;
`endif

  assign dataOut       = dout_q;
  assign dataOutEnable = oe_q;
  assign ready         = ready_q;

endmodule

// File: tb/tb_bus_responder.sv
// tb_bus_responder
// Drives two responders (WAIT_STATES=2 at index 0, WAIT_STATES=0 at index 1)
// from the same strobe stimulus. A transaction-level model counts how long
// the accepted strobe has been held low: ready is expected once that run
// reaches WAIT_STATES+1 and until the strobe releases.
module tb_bus_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic        notRD = 1'b1;
  logic        notWR = 1'b1;
  logic [7:0]  address = 8'h00;
  logic [15:0] dataIn = 16'h0000;

  logic [15:0] dout [2];
  logic        oe   [2];
  logic        rdy  [2];
`ifdef BUS_ERROR_EN
  logic        err  [2];
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  bus_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(2)) u_ws2 (
    .clock(clock), .reset(reset), .notRD(notRD), .notWR(notWR),
    .address(address), .dataIn(dataIn), .dataOut(dout[0]),
    .dataOutEnable(oe[0]), .ready(rdy[0])
`ifdef BUS_ERROR_EN
    , .busError(err[0])
`endif
  );

  bus_responder #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .WAIT_STATES(0)) u_ws0 (
    .clock(clock), .reset(reset), .notRD(notRD), .notWR(notWR),
    .address(address), .dataIn(dataIn), .dataOut(dout[1]),
    .dataOutEnable(oe[1]), .ready(rdy[1])
`ifdef BUS_ERROR_EN
    , .busError(err[1])
`endif
  );

  // ---------------- behavioural model ----------------
  int          W [2] = '{2, 0};
  logic [15:0] m_mem  [2][256];
  int          m_act  [2];      // 0 none, 1 read, 2 write
  int          m_run  [2];
  logic [7:0]  m_addr [2];
  logic [15:0] m_data [2];
  logic        m_prevRd, m_prevWr;
  logic        exp_ready [2];
  logic        exp_oe    [2];
  logic [15:0] exp_dout  [2];
  logic        exp_err   [2];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_act[i] = 0; m_run[i] = 0;
        exp_ready[i] = 1'b0; exp_oe[i] = 1'b0;
        exp_dout[i] = 16'h0000; exp_err[i] = 1'b0;
      end
      m_prevRd = 1'b1;
      m_prevWr = 1'b1;
    end else begin
      for (int i = 0; i < 2; i++) begin
        exp_err[i] = 1'b0;
        if (m_act[i] == 0) begin
          if (!notRD && !notWR) begin
            exp_err[i] = m_prevRd || m_prevWr;
          end else if ((!notRD && m_prevRd) || (!notWR && m_prevWr)) begin
            m_act[i]  = !notWR ? 2 : 1;
            m_run[i]  = 1;
            m_addr[i] = address;
            m_data[i] = dataIn;
          end
        end else begin
          if ((m_act[i] == 1 ? notRD : notWR) == 1'b0) begin
            m_run[i]++;
          end else begin
            exp_err[i] = (m_run[i] < W[i] + 1);
            m_act[i] = 0;
            m_run[i] = 0;
          end
        end
        if (m_act[i] != 0 && m_run[i] == W[i] + 1) begin
          if (m_act[i] == 2) m_mem[i][m_addr[i]] = m_data[i];
          else               exp_dout[i] = m_mem[i][m_addr[i]];
        end
        exp_ready[i] = (m_act[i] != 0) && (m_run[i] >= W[i] + 1);
        exp_oe[i]    = exp_ready[i] && (m_act[i] == 1);
      end
      m_prevRd = notRD;
      m_prevWr = notWR;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("ready ws=%0d", W[i]), {15'd0, rdy[i]}, {15'd0, exp_ready[i]});
      chk($sformatf("oe ws=%0d", W[i]), {15'd0, oe[i]}, {15'd0, exp_oe[i]});
      chk($sformatf("dataOut ws=%0d", W[i]), dout[i], exp_dout[i]);
`ifdef BUS_ERROR_EN
      chk($sformatf("busError ws=%0d", W[i]), {15'd0, err[i]}, {15'd0, exp_err[i]});
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic access(input bit wr, input logic [7:0] a, input logic [15:0] d, input int low);
    address = a;
    dataIn  = d;
    if (wr) notWR = 1'b0;
    else    notRD = 1'b0;
    cyc(low);
    notWR = 1'b1;
    notRD = 1'b1;
    cyc(2);
  endtask

  initial begin
    reset = 1'b1;
    cyc(2);
    chk("reset ready", {15'd0, rdy[0]}, 16'h0000);
    chk("reset oe", {15'd0, oe[0]}, 16'h0000);
    chk("reset dataOut", dout[0], 16'h0000);
    reset = 1'b0;
    cyc(2);

    // Write BEEF to 05, notWR low 4 cycles; bus values change after E0.
    address = 8'h05; dataIn = 16'hBEEF; notWR = 1'b0;
    cyc(1);
    chk("wr E0 ready ws2", {15'd0, rdy[0]}, 16'h0000);
    chk("wr E0 ready ws0", {15'd0, rdy[1]}, 16'h0001);
    address = 8'h77; dataIn = 16'h0000;
    cyc(1);
    chk("wr E0+1 ready ws2", {15'd0, rdy[0]}, 16'h0000);
    cyc(1);
    chk("wr E0+2 ready ws2", {15'd0, rdy[0]}, 16'h0001);
    cyc(1);
    notWR = 1'b1;
    cyc(1);
    chk("wr release ready ws2", {15'd0, rdy[0]}, 16'h0000);
    chk("wr release ready ws0", {15'd0, rdy[1]}, 16'h0000);
    cyc(1);

    // Read 05.
    address = 8'h05; notRD = 1'b0;
    cyc(1);
    chk("rd E0 dataOut ws0", dout[1], 16'hBEEF);
    chk("rd E0 oe ws0", {15'd0, oe[1]}, 16'h0001);
    chk("rd E0 oe ws2", {15'd0, oe[0]}, 16'h0000);
    cyc(2);
    chk("rd E0+2 dataOut ws2", dout[0], 16'hBEEF);
    chk("rd E0+2 oe ws2", {15'd0, oe[0]}, 16'h0001);
    cyc(1);
    notRD = 1'b1;
    cyc(1);
    chk("rd release oe ws2", {15'd0, oe[0]}, 16'h0000);
    chk("rd release dataOut hold ws2", dout[0], 16'hBEEF);
    cyc(1);

    // Write/read back at the top address.
    access(1'b1, 8'hFF, 16'h1234, 3);
    access(1'b0, 8'hFF, 16'h0000, 3);
    chk("rdback FF ws2", dout[0], 16'h1234);
    chk("rdback FF ws0", dout[1], 16'h1234);

    // Short write pulse: aborts with 2 wait states, commits with 0.
    access(1'b1, 8'h10, 16'hA5A5, 3);
    access(1'b1, 8'h10, 16'h0000, 1);
    access(1'b0, 8'h10, 16'hFFFF, 3);
    chk("abort keeps 10 ws2", dout[0], 16'hA5A5);
    chk("short write 10 ws0", dout[1], 16'h0000);

    // Both strobes low together: no access.
    address = 8'h05; dataIn = 16'h0000; notRD = 1'b0; notWR = 1'b0;
    cyc(3);
    chk("both low ready ws2", {15'd0, rdy[0]}, 16'h0000);
    chk("both low ready ws0", {15'd0, rdy[1]}, 16'h0000);
    notRD = 1'b1; notWR = 1'b1;
    cyc(2);
    access(1'b0, 8'h05, 16'h0000, 3);
    chk("both low store ws2", dout[0], 16'hBEEF);
    chk("both low store ws0", dout[1], 16'hBEEF);

    // Reset during the wait of a write.
    address = 8'h05; dataIn = 16'h1111; notWR = 1'b0;
    cyc(2);
    reset = 1'b1; notWR = 1'b1;
    #1;
    chk("mid reset ready ws0", {15'd0, rdy[1]}, 16'h0000);
    chk("mid reset dataOut ws0", dout[1], 16'h0000);
    chk("mid reset oe ws2", {15'd0, oe[0]}, 16'h0000);
    chk("mid reset dataOut ws2", dout[0], 16'h0000);
    cyc(1);
    reset = 1'b0;
    cyc(2);
    access(1'b0, 8'h05, 16'h0000, 3);
    chk("after reset read ws2", dout[0], 16'hBEEF);
    chk("after reset read ws0", dout[1], 16'h1111);

    cyc(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_responder.md
Name: bus_responder

Overview:
- Memory-side responder for the CPU's registered, active-low read/write strobe pair (notRD/notWR).
- Detects strobe assertion, inserts a programmable number of wait states, then completes the access:
  - a read drives data onto the bus with an output enable;
  - a write commits bus data into an internal word store.
- Signals completion with ready. Sits on the system bus opposite the CPU strobe generator, clocked from the same clock.

Parameters:
- DATA_WIDTH, 16, bus data width in bits.
- ADDR_WIDTH, 8, address width; internal store depth is 2**ADDR_WIDTH words.
- WAIT_STATES, 2, wait cycles inserted before completion; legal range 0..15.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- notRD  input  1  active-low read strobe from CPU.
- notWR  input  1  active-low write strobe from CPU.
- address  input  ADDR_WIDTH  word address; valid while a strobe is low.
- dataIn  input  DATA_WIDTH  write data; valid while notWR is low.
- dataOut  output  DATA_WIDTH  read data.
- dataOutEnable  output  1  high while dataOut is to be driven onto the bus.
- ready  output  1  access complete; held until strobe release.
- busError  output  1  present only with BUS_ERROR_EN.

Behaviour:
- Reset (async, high):
  - state=IDLE; dataOut=0; dataOutEnable=0; ready=0; busError=0.
  - Previous-strobe registers are set to 1 (deasserted).
  - Store contents are not cleared.
- Strobes are sampled on the rising edge. Assertion = sampled low while the previous sample was high; detected only in IDLE.
- States:
  - IDLE
  - WAIT: 4-bit counter.
  - DONE: ready=1.
- At assertion edge E0 (single strobe):
  - Latch address into addrQ; for a write, also latch dataIn into dataQ.
  - Go to WAIT with count=WAIT_STATES, or straight to DONE if WAIT_STATES=0.
- WAIT: decrement each edge; the edge where count==1 enters DONE. ready therefore rises after edge E0+WAIT_STATES.
- Edge entering DONE:
  - Read: dataOut <= store[addrQ]; dataOutEnable <= 1; ready <= 1.
  - Write: store[addrQ] <= dataQ; ready <= 1; dataOutEnable stays 0.
- DONE holds until the active strobe samples high. On that edge: state=IDLE; ready=0; dataOutEnable=0; dataOut keeps its value.
- A new assertion is recognised no earlier than the edge after return to IDLE. A strobe held low continuously never retriggers.
- Strobe released during WAIT = abort:
  - Return to IDLE; no store write; ready never rises.
- Both strobes sampled low at the same edge in IDLE: no access, stay IDLE.
- Strobe swap while busy (the other strobe asserts) is ignored until IDLE.
- address/dataIn changes after E0 have no effect; the latched values are used.
- Reset mid-access: immediate IDLE and outputs to reset values. A write not yet committed is lost.

Optional Feature:
- Macro: BUS_ERROR_EN.
- Defined:
  - busError port exists. It pulses high for exactly one cycle, on the edge after both strobes are sampled low in IDLE, and on the edge a strobe releases during WAIT (abort).
  - Behaviour is otherwise identical.
- Undefined: port and logic are absent; the same conditions are silently ignored.

Decomposition:
- Shared package (include file with guard):
  - state encodings IDLE=2'd0, WAIT=2'd1, DONE=2'd2;
  - default widths;
  - WAIT_STATES maximum (15).
- One sub-module: strobe_edge_detect. It holds the registered previous value of both strobes (reset to 1) and outputs rdAssert, wrAssert, bothLow, rdLevel and wrLevel.

Test Plan:
- WAIT_STATES=2; write 16'hBEEF to address 8'h05 (notWR low 4 cycles) -> ready rises 2 edges after E0, stays until notWR high, then drops on the next edge; store[5]=BEEF.
- Read address 8'h05 -> dataOut=16'hBEEF and dataOutEnable=1 together with ready, 2 edges after E0; both clear on the edge notRD samples high.
- WAIT_STATES=0; write 16'h1234 to 8'hFF, then read it back -> ready after E0 for each; dataOut=1234.
- Write 16'h0000 to 8'h10, pulsing notWR low for only 1 cycle (abort in WAIT) -> ready never rises; a following read of 8'h10 returns the prior value; busError pulses once if BUS_ERROR_EN.
- notRD and notWR low on the same edge -> no ready, no store change; busError one-cycle pulse with BUS_ERROR_EN.
- Assert reset during WAIT of a write -> outputs zero immediately; store unchanged; next read completes normally.
